// File: rtl/ctrl_pkg.sv
// Shared types for the control pipeline: control bundle,
// stage-register layouts and forwarding/ALUOp encodings.
package ctrl_pkg;

  localparam int REG_W = 5;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  typedef logic [REG_W-1:0] reg_idx_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic [1:0] alu_op;
  } ctrl_t;

  typedef struct packed {
    ctrl_t    ctrl;
    reg_idx_t rs1;
    reg_idx_t rs2;
    reg_idx_t rd;
  } id_ex_t;

  typedef struct packed {
    logic     reg_write;
    logic     mem_to_reg;
    logic     mem_read;
    logic     mem_write;
    reg_idx_t rd;
  } ex_mem_t;

  typedef struct packed {
    logic     reg_write;
    logic     mem_to_reg;
    reg_idx_t rd;
  } mem_wb_t;

  localparam ctrl_t CTRL_BUBBLE = '{
    alu_op:  ALU_ADD,
    default: 1'b0
  };

  // x0 is hardwired to zero, so it never produces a match
  function automatic logic src_hit(
    input logic     wr,
    input reg_idx_t rd,
    input reg_idx_t rs
  );
    return wr && (rd != '0) && (rd == rs);
  endfunction

endpackage

// File: rtl/ctrl_pipe_forward_unit.sv
// EX operand forwarding selects from the MEM and WB
// destination registers; MEM wins over WB.
module forward_unit
  import ctrl_pkg::*;
(
  input  reg_idx_t   ex_rs1,
  input  reg_idx_t   ex_rs2,
  input  logic       mem_reg_write,
  input  reg_idx_t   mem_rd,
  input  logic       wb_reg_write,
  input  reg_idx_t   wb_rd,
  output logic [1:0] forward_a,
  output logic [1:0] forward_b
);

  always_comb begin
    forward_a = FWD_REG;
    if (src_hit(mem_reg_write, mem_rd, ex_rs1))
      forward_a = FWD_MEM;
    else if (src_hit(wb_reg_write, wb_rd, ex_rs1))
      forward_a = FWD_WB;
  end

  always_comb begin
    forward_b = FWD_REG;
    if (src_hit(mem_reg_write, mem_rd, ex_rs2))
      forward_b = FWD_MEM;
    else if (src_hit(wb_reg_write, wb_rd, ex_rs2))
      forward_b = FWD_WB;
  end

endmodule

// File: rtl/ctrl_pipe.sv
// Control bundle pipeline ID->EX->MEM->WB with load-use
// hazard detection, bubble insertion and branch flush.
module ctrl_pipe
  import ctrl_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       stall_i,
  input  logic       RegWrite_i,
  input  logic       MemtoReg_i,
  input  logic       MemRead_i,
  input  logic       MemWrite_i,
  input  logic       ALUSrc_i,
  input  logic [1:0] ALUOp_i,
  input  logic [4:0] rs1_id_i,
  input  logic [4:0] rs2_id_i,
  input  logic [4:0] rd_id_i,
  input  logic       branch_taken_i,
  output logic       noop_o,
  output logic       pc_write_o,
  output logic       ifid_write_o,
  output logic       ifid_flush_o,
  output logic [1:0] ex_ALUOp_o,
  output logic       ex_ALUSrc_o,
  output logic [4:0] ex_rd_o,
  output logic [1:0] forward_a_o,
  output logic [1:0] forward_b_o,
  output logic       mem_MemRead_o,
  output logic       mem_MemWrite_o,
  output logic [4:0] mem_rd_o,
  output logic       wb_RegWrite_o,
  output logic       wb_MemtoReg_o,
  output logic [4:0] wb_rd_o
);

  id_ex_t  id_ex_q,  id_ex_d;
  ex_mem_t ex_mem_q, ex_mem_d;
  mem_wb_t mem_wb_q, mem_wb_d;
  ctrl_t   id_ctrl;
  logic    hazard;

  assign id_ctrl = {RegWrite_i, MemtoReg_i, MemRead_i,
                    MemWrite_i, ALUSrc_i, ALUOp_i};

  // Only register state and ID indices feed this, never the
  // bundle, so noop_o cannot loop back through the decoder.
  assign hazard = id_ex_q.ctrl.mem_read
               && (id_ex_q.rd != '0)
               && ((id_ex_q.rd == rs1_id_i)
                || (id_ex_q.rd == rs2_id_i));

  assign noop_o       = hazard;
  assign pc_write_o   = ~stall_i & ~hazard;
  assign ifid_write_o = ~stall_i & ~hazard;
  assign ifid_flush_o = branch_taken_i & ~hazard & ~stall_i;

  always_comb begin
    id_ex_d = id_ex_q;
    if (!stall_i) begin
      if (hazard) begin
        id_ex_d      = '0;
        id_ex_d.ctrl = CTRL_BUBBLE;
      end else begin
        id_ex_d.ctrl = id_ctrl;
        id_ex_d.rs1  = rs1_id_i;
        id_ex_d.rs2  = rs2_id_i;
        id_ex_d.rd   = rd_id_i;
      end
    end
  end

  always_comb begin
    ex_mem_d = ex_mem_q;
    if (!stall_i) begin
      ex_mem_d.reg_write  = id_ex_q.ctrl.reg_write;
      ex_mem_d.mem_to_reg = id_ex_q.ctrl.mem_to_reg;
      ex_mem_d.mem_read   = id_ex_q.ctrl.mem_read;
      ex_mem_d.mem_write  = id_ex_q.ctrl.mem_write;
      ex_mem_d.rd         = id_ex_q.rd;
    end
  end

  always_comb begin
    mem_wb_d = mem_wb_q;
    if (!stall_i) begin
      mem_wb_d.reg_write  = ex_mem_q.reg_write;
      mem_wb_d.mem_to_reg = ex_mem_q.mem_to_reg;
      mem_wb_d.rd         = ex_mem_q.rd;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      id_ex_q  <= '0;
      ex_mem_q <= '0;
      mem_wb_q <= '0;
    end else begin
      id_ex_q  <= id_ex_d;
      ex_mem_q <= ex_mem_d;
      mem_wb_q <= mem_wb_d;
    end
  end

  assign ex_ALUOp_o     = id_ex_q.ctrl.alu_op;
  assign ex_ALUSrc_o    = id_ex_q.ctrl.alu_src;
  assign ex_rd_o        = id_ex_q.rd;
  assign mem_MemRead_o  = ex_mem_q.mem_read;
  assign mem_MemWrite_o = ex_mem_q.mem_write;
  assign mem_rd_o       = ex_mem_q.rd;
  assign wb_RegWrite_o  = mem_wb_q.reg_write;
  assign wb_MemtoReg_o  = mem_wb_q.mem_to_reg;
  assign wb_rd_o        = mem_wb_q.rd;

  forward_unit u_fwd (
    .ex_rs1        (id_ex_q.rs1),
    .ex_rs2        (id_ex_q.rs2),
    .mem_reg_write (ex_mem_q.reg_write),
    .mem_rd        (ex_mem_q.rd),
    .wb_reg_write  (mem_wb_q.reg_write),
    .wb_rd         (mem_wb_q.rd),
    .forward_a     (forward_a_o),
    .forward_b     (forward_b_o)
  );

endmodule
